ultrasonic_note_scanner: RTL and testbench



---
 rtl/ultrasonic_note_scanner.sv | 227 ++++++++++++++++++++++
 tb/tb_ultrasonic_note_scanner.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_note_scanner.sv
// rtl/ultrasonic_note_scanner.sv - time-multiplexed ultrasonic ranging front end with note quantiser and stability filter
module ultrasonic_note_scanner #(
   parameter int NUM_CH         = 2,
   parameter int TRIG_CYCLES    = 500,
   parameter int TIMEOUT_CYCLES = 1_500_000,
   parameter int GAP_CYCLES     = 3_000_000,
   parameter int BUCKET_CYCLES  = 14_500,
   parameter int NUM_NOTES      = 8,
   parameter int NOTE_W         = 4,
   parameter int STABLE_N       = 3,
   localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     CLOCK_50,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [NUM_CH-1:0]        echo,
   output logic [NUM_CH-1:0]        trig,
   output logic [NUM_CH*NOTE_W-1:0] note,
   output logic [NUM_CH-1:0]        note_valid,
   output logic                     update,
   output logic [CH_W-1:0]          update_ch,
   output logic                     busy
);

   // note counter carries one extra bit so it can saturate at NUM_NOTES
   localparam int NC_W  = NOTE_W + 1;
   localparam int RUN_W = $clog2(STABLE_N + 1);

   localparam logic [31:0]       L_TRIG_LAST = 32'(TRIG_CYCLES - 1);
   localparam logic [31:0]       L_TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0]       L_GAP_LAST  = 32'(GAP_CYCLES - 1);
   localparam logic [31:0]       L_BKT_LAST  = 32'(BUCKET_CYCLES - 1);
   localparam logic [NC_W-1:0]   L_NOTE_SAT  = NC_W'(NUM_NOTES);
   localparam logic [RUN_W-1:0]  L_RUN_MAX   = RUN_W'(STABLE_N);
   localparam logic [CH_W-1:0]   L_PTR_LAST  = CH_W'(NUM_CH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_TRIG,
      S_WAIT_RISE,
      S_MEASURE,
      S_EVAL,
      S_GAP
   } state_t;

   state_t                    r_state;
   state_t                    w_next;
   logic [CH_W-1:0]           r_ptr;
   logic [CH_W-1:0]           w_ptr_next;

   logic [NUM_CH-1:0]         r_echo_s1;
   logic [NUM_CH-1:0]         r_echo_s2;
   logic                      r_echo_prev;

   logic [31:0]               r_cnt;
   logic [31:0]               r_tmo;
   logic [31:0]               r_sub;
   logic [NC_W-1:0]           r_notec;
   logic                      r_timed_out;

   logic [NUM_CH-1:0]         r_trig;
   logic [NUM_CH*NOTE_W-1:0]  r_note;
   logic [NUM_CH-1:0]         r_note_valid;
   logic                      r_update;
   logic [CH_W-1:0]           r_update_ch;

   logic [NUM_CH-1:0]         r_cand_v;
   logic [NOTE_W-1:0]         r_cand_n [NUM_CH];
   logic [RUN_W-1:0]          r_run    [NUM_CH];

   logic                      w_echo;
   logic                      w_rise;
   logic                      w_trig_done;
   logic                      w_gap_done;
   logic                      w_tmo_hit;
   logic                      w_count;
   logic                      w_rd_valid;
   logic [NOTE_W-1:0]         w_rd_note;
   logic                      w_same;
   logic                      w_pub_same;
   logic [RUN_W-1:0]          w_run_new;
   logic                      w_publish;
   logic [NOTE_W-1:0]         w_pub_note;

   assign w_echo      = r_echo_s2[r_ptr];
   assign w_rise      = w_echo && !r_echo_prev;
   assign w_trig_done = (r_cnt == L_TRIG_LAST);
   assign w_gap_done  = (r_cnt == L_GAP_LAST);
   assign w_tmo_hit   = (r_tmo == L_TMO_LAST);

   // the rising-edge cycle is already a high cycle, so it is counted before MEASURE
   assign w_count = ((r_state == S_WAIT_RISE) && w_rise && !w_tmo_hit)
                 || ((r_state == S_MEASURE) && w_echo);

   assign w_rd_valid = !r_timed_out && (r_notec < L_NOTE_SAT);
   assign w_rd_note  = r_notec[NOTE_W-1:0];
   assign w_pub_note = r_note[int'(r_ptr)*NOTE_W +: NOTE_W];

   // two invalid readings compare equal whatever their note field holds
   assign w_same     = (w_rd_valid == r_cand_v[r_ptr])
                    && (!w_rd_valid || (w_rd_note == r_cand_n[r_ptr]));
   assign w_pub_same = (w_rd_valid == r_note_valid[r_ptr])
                    && (!w_rd_valid || (w_rd_note == w_pub_note));
   assign w_run_new  = !w_same ? RUN_W'(1)
                     : (r_run[r_ptr] == L_RUN_MAX) ? L_RUN_MAX
                     : r_run[r_ptr] + RUN_W'(1);
   assign w_publish  = (w_run_new == L_RUN_MAX) && !w_pub_same;

   assign trig       = r_trig;
   assign note       = r_note;
   assign note_valid = r_note_valid;
   assign update     = r_update;
   assign update_ch  = r_update_ch;
   assign busy       = (r_state != S_IDLE);

   // two-flop synchroniser for the asynchronous echo lines
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_echo_s1 <= '0;
         r_echo_s2 <= '0;
      end else begin
         r_echo_s1 <= echo;
         r_echo_s2 <= r_echo_s1;
      end
   end

   // next-state and channel pointer selection
   always_comb begin
      w_next     = r_state;
      w_ptr_next = r_ptr;
      unique case (r_state)
         S_IDLE:      if (enable) w_next = S_TRIG;
         S_TRIG:      if (w_trig_done) w_next = S_WAIT_RISE;
         S_WAIT_RISE: begin
            if (w_tmo_hit)   w_next = S_EVAL;
            else if (w_rise) w_next = S_MEASURE;
         end
         S_MEASURE:   if (!w_echo || w_tmo_hit) w_next = S_EVAL;
         S_EVAL:      w_next = S_GAP;
         S_GAP: begin
            if (w_gap_done) begin
               w_ptr_next = (r_ptr == L_PTR_LAST) ? '0 : r_ptr + CH_W'(1);
               w_next     = enable ? S_TRIG : S_IDLE;
            end
         end
         default:     w_next = S_IDLE;
      endcase
   end

   // state, counters, trigger and filter registers
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_ptr        <= '0;
         r_echo_prev  <= 1'b0;
         r_cnt        <= '0;
         r_tmo        <= '0;
         r_sub        <= '0;
         r_notec      <= '0;
         r_timed_out  <= 1'b0;
         r_trig       <= '0;
         r_note       <= '0;
         r_note_valid <= '0;
         r_update     <= 1'b0;
         r_update_ch  <= '0;
         r_cand_v     <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            r_cand_n[c] <= '0;
            r_run[c]    <= '0;
         end
      end else begin
         r_state     <= w_next;
         r_ptr       <= w_ptr_next;
         r_echo_prev <= w_echo;
         r_update    <= 1'b0;

         r_trig <= '0;
         if (w_next == S_TRIG) r_trig[w_ptr_next] <= 1'b1;

         if (w_count) begin
            if (r_sub == L_BKT_LAST) begin
               r_sub <= '0;
               if (r_notec != L_NOTE_SAT) r_notec <= r_notec + NC_W'(1);
            end else begin
               r_sub <= r_sub + 32'd1;
            end
         end

         unique case (r_state)
            S_IDLE: r_cnt <= '0;
            S_TRIG: begin
               if (w_trig_done) begin
                  r_cnt       <= '0;
                  r_tmo       <= '0;
                  r_sub       <= '0;
                  r_notec     <= '0;
                  r_timed_out <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end
            S_WAIT_RISE: begin
               r_tmo <= r_tmo + 32'd1;
               if (w_tmo_hit) r_timed_out <= 1'b1;
            end
            S_MEASURE: begin
               r_tmo <= r_tmo + 32'd1;
               if (w_tmo_hit && w_echo) r_timed_out <= 1'b1;
            end
            S_EVAL: begin
               r_cand_v[r_ptr] <= w_rd_valid;
               r_cand_n[r_ptr] <= w_rd_note;
               r_run[r_ptr]    <= w_run_new;
               if (w_publish) begin
                  r_note[int'(r_ptr)*NOTE_W +: NOTE_W] <= w_rd_valid ? w_rd_note : '0;
                  r_note_valid[r_ptr]                  <= w_rd_valid;
                  r_update                             <= 1'b1;
                  r_update_ch                          <= r_ptr;
               end
            end
            S_GAP: r_cnt <= w_gap_done ? '0 : r_cnt + 32'd1;
            default: r_cnt <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_ultrasonic_note_scanner.sv
// tb/tb_ultrasonic_note_scanner.sv - self-checking bench for ultrasonic_note_scanner
module tb_ultrasonic_note_scanner;

   localparam int TMO = 200;

   logic       clk;
   logic       reset;
   logic       enable;
   logic [1:0] echo;
   logic [1:0] trig;
   logic [7:0] note;
   logic [1:0] note_valid;
   logic       update;
   logic [0:0] update_ch;
   logic       busy;

   int n_cmp  = 0;
   int n_fail = 0;
   int exp_wait = -1;

   // reference filter: last three readings per channel and the published value
   bit hv [2][3];
   int hn [2][3];
   int hc [2];
   bit pv [2];
   int pn [2];

   typedef struct {
      int d;
      int w;
      bit upd;
      int note;
      bit valid;
   } vec_t;

   vec_t v0 [20];

   ultrasonic_note_scanner #(
      .NUM_CH(2), .TRIG_CYCLES(4), .TIMEOUT_CYCLES(TMO), .GAP_CYCLES(10),
      .BUCKET_CYCLES(10), .NUM_NOTES(8), .NOTE_W(4), .STABLE_N(3)
   ) dut (
      .CLOCK_50(clk), .reset(reset), .enable(enable), .echo(echo),
      .trig(trig), .note(note), .note_valid(note_valid), .update(update),
      .update_ch(update_ch), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         hc[c] = 0;
         pv[c] = 1'b0;
         pn[c] = 0;
         for (int k = 0; k < 3; k++) begin
            hv[c][k] = 1'b0;
            hn[c][k] = 0;
         end
      end
   endtask

   function automatic bit same(input bit av, input int an, input bit bv, input int bn);
      return (av == bv) && (!av || an == bn);
   endfunction

   // a reading is the echo width in whole buckets; no echo or overrunning echo is invalid
   task automatic reading(input int d, input int w, output bit v, output int n, output int ie);
      if (w == 0 || d + w + 2 >= TMO - 1) begin
         v = 1'b0; n = 0; ie = TMO;
      end else begin
         n = w / 10; v = (n < 8); ie = d + w + 3;
      end
   endtask

   task automatic model_step(input int ch, input bit rv, input int rn, output bit upd);
      hv[ch][2] = hv[ch][1]; hn[ch][2] = hn[ch][1];
      hv[ch][1] = hv[ch][0]; hn[ch][1] = hn[ch][0];
      hv[ch][0] = rv;        hn[ch][0] = rn;
      if (hc[ch] < 3) hc[ch]++;
      upd = 1'b0;
      if (hc[ch] == 3 && same(hv[ch][0], hn[ch][0], hv[ch][1], hn[ch][1])
          && same(hv[ch][1], hn[ch][1], hv[ch][2], hn[ch][2])
          && !same(rv, rn, pv[ch], pn[ch])) begin
         upd = 1'b1;
         pv[ch] = rv;
         pn[ch] = rv ? rn : 0;
      end
   endtask

   // one full scan of channel ch: echo rises d cycles after trig falls and lasts w cycles
   task automatic do_scan(input int ch, input int d, input int w, input bit use_tbl,
                          input bit t_upd, input int t_note, input bit t_v,
                          input int drop_en_at, input int rst_at);
      int n, hi, ie, rn, bad_upd, bad_busy, e_note;
      bit rv, m_upd, e_upd, e_v;
      bad_upd = 0; bad_busy = 0;
      n = 0;
      while (trig == 2'b00 && n < 400) begin
         tick();
         n++;
         if (update) bad_upd++;
      end
      check("trig_start", (trig != 2'b00), 1);
      if (exp_wait >= 0) check("gap_len", n, exp_wait);
      check("trig_onehot", trig, 1 << ch);
      hi = 0;
      while (trig == (2'b01 << ch) && hi < 20) begin
         hi++;
         if (!busy) bad_busy++;
         tick();
      end
      check("trig_len", hi, 4);
      check("trig_fall", trig, 0);
      reading(d, w, rv, rn, ie);
      e_upd = t_upd; e_note = t_note; e_v = t_v;
      if (rst_at < 0) begin
         model_step(ch, rv, rn, m_upd);
         if (!use_tbl) begin
            e_upd = m_upd; e_note = pn[ch]; e_v = pv[ch];
         end
      end
      for (int i = 1; i <= ie + 1; i++) begin
         tick();
         echo[ch] = (i >= d && i < d + w);
         if (i == drop_en_at) enable = 1'b0;
         if (i == rst_at) begin
            reset = 1'b1;
            tick();
            check("rst_trig", trig, 0);
            check("rst_note", note, 0);
            check("rst_valid", note_valid, 0);
            check("rst_update", update, 0);
            check("rst_update_ch", update_ch, 0);
            check("rst_busy", busy, 0);
            reset = 1'b0;
            echo = 2'b00;
            model_reset();
            exp_wait = -1;
            return;
         end
         if (!busy) bad_busy++;
         if (trig != 2'b00) bad_busy++;
         if (i <= ie && update) bad_upd++;
      end
      check("update", update, e_upd);
      if (e_upd) check("update_ch", update_ch, ch);
      check("note", note[ch*4 +: 4], e_note);
      check("note_valid", note_valid[ch], e_v);
      check("stray_update", bad_upd, 0);
      check("busy_trig_in_scan", bad_busy, 0);
      echo[ch] = 1'b0;
      exp_wait = 10;
   endtask

   initial begin
      int ch, d, w, pick;
      v0 = '{
         '{3, 35, 1'b0, 0, 1'b0}, '{3, 35, 1'b0, 0, 1'b0}, '{3, 35, 1'b1, 3, 1'b1},
         '{4, 29, 1'b0, 3, 1'b1}, '{4, 29, 1'b0, 3, 1'b1}, '{4, 29, 1'b1, 2, 1'b1},
         '{6, 30, 1'b0, 2, 1'b1}, '{6, 30, 1'b0, 2, 1'b1}, '{6, 30, 1'b1, 3, 1'b1},
         '{2, 85, 1'b0, 3, 1'b1}, '{2, 85, 1'b0, 3, 1'b1}, '{2, 85, 1'b1, 0, 1'b0},
         '{3, 35, 1'b0, 0, 1'b0}, '{3, 45, 1'b0, 0, 1'b0}, '{3, 35, 1'b0, 0, 1'b0},
         '{3, 45, 1'b0, 0, 1'b0}, '{3, 35, 1'b0, 0, 1'b0}, '{3, 45, 1'b0, 0, 1'b0},
         '{3, 45, 1'b0, 0, 1'b0}, '{3, 45, 1'b1, 4, 1'b1}
      };
      model_reset();
      reset = 1'b1; enable = 1'b1; echo = 2'b00;
      repeat (3) tick();
      check("reset_trig", trig, 0);
      check("reset_note", note, 0);
      check("reset_valid", note_valid, 0);
      check("reset_update", update, 0);
      check("reset_update_ch", update_ch, 0);
      check("reset_busy", busy, 0);
      reset = 1'b0;

      // directed table: ch0 rows interleaved with ch1 rows that never see a valid echo
      for (int k = 0; k < 20; k++) begin
         do_scan(0, v0[k].d, v0[k].w, 1'b1, v0[k].upd, v0[k].note, v0[k].valid, -1, -1);
         do_scan(1, 5, (k % 4 == 1) ? 250 : 0, 1'b1, 1'b0, 0, 1'b0, -1, -1);
      end

      // enable dropped mid-measurement: scan completes, GAP runs out, FSM parks in IDLE
      do_scan(0, 3, 45, 1'b0, 1'b0, 0, 1'b0, 20, -1);
      repeat (9) tick();
      check("busy_end_gap", busy, 1);
      tick();
      check("busy_idle", busy, 0);
      repeat (5) tick();
      check("idle_trig", trig, 0);
      check("idle_busy", busy, 0);
      enable = 1'b1;
      exp_wait = -1;
      do_scan(1, 2, 0, 1'b0, 1'b0, 0, 1'b0, -1, -1);

      // reset in the middle of a ch0 measurement, then the filter must start from scratch
      do_scan(0, 3, 45, 1'b0, 1'b0, 0, 1'b0, -1, 20);
      for (int k = 0; k < 5; k++)
         do_scan(k % 2, 3, (k % 2 == 1) ? 0 : 45, 1'b0, 1'b0, 0, 1'b0, -1, -1);

      // randomised scans against the reference filter
      for (int k = 0; k < 30; k++) begin
         ch = (k + 1) % 2;
         d = $urandom_range(1, 20);
         pick = $urandom_range(0, 7);
         case (pick)
            0:       w = 0;
            1:       w = 250;
            2, 3:    w = 35;
            4:       w = 45;
            5:       w = 85;
            default: w = $urandom_range(1, 100);
         endcase
         do_scan(ch, d, w, 1'b0, 1'b0, 0, 1'b0, -1, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
